data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Multi-cycle data-memory target serving the pipeline's MEM-stage load/store port.
//   Accepts one request over a valid/ready handshake and inserts WAIT_CYCLES wait states.
//   Returns one response over a valid/ready handshake.
//   MEM stage stalls on !req_ready or !rsp_valid; replaces the zero-latency data memory.
// PARAMETERS
//   DEPTH_WORDS  1024  32-bit words of storage; power of two
//   WAIT_CYCLES  2     wait states between accept and response; 0..15
// PORTS
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous, active-low reset
//   req_valid    in   1   initiator presents request
//   req_write    in   1   1=store, 0=load
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data
//   req_ready    out  1   responder can accept
//   rsp_valid    out  1   response available
//   rsp_ready    in   1   initiator takes response
//   rsp_rdata    out  32  load data; 0 for stores
//   rsp_err      out  1   misaligned-access error (MISALIGN_ERR_EN only)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, wait counter=0, captured request cleared.
//     Outputs during reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//     Storage array is not cleared.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1, rsp_valid=0.
//     Accept edge = clk edge with req_valid & req_ready.
//     At accept: latch write, word index, wdata.
//     Next state is WAIT with cnt=WAIT_CYCLES-1, or RESP if WAIT_CYCLES=0.
//   WAIT: req_ready=0. cnt decrements each cycle. Leaves for RESP on the edge where cnt=0.
//   Entry to RESP (single edge):
//     Store: mem[idx] <= wdata; rsp_rdata <= 0.
//     Load: rsp_rdata <= mem[idx].
//   RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err held stable until rsp_ready=1.
//     On rsp_valid & rsp_ready edge -> IDLE; rsp_valid drops next cycle.
//   Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
//     Throughput: at most one request per WAIT_CYCLES+2 cycles.
//   Index: idx = req_addr[$clog2(DEPTH_WORDS)+1:2]. Higher address bits are ignored,
//     so addresses wrap modulo DEPTH_WORDS*4.
//   Ordering: a store commits before its response, so a following load to the
//     same address returns the new data.
//   Request inputs are ignored outside IDLE; the initiator must hold them until accepted.
//   Reset mid-transaction: transaction is dropped, no response is issued.
//     A store asserted before the RESP-entry edge is not committed.
// CONFIGURATION
//   MISALIGN_ERR_EN defined:
//     req_addr[1:0]!=0 -> store suppressed, rsp_rdata=0, rsp_err=1.
//     Same latency and handshake as a normal access.
//   MISALIGN_ERR_EN undefined: req_addr[1:0] ignored; rsp_err tied to 0.
// TESTING
//   1. Reset/store/load, WAIT_CYCLES=2, rsp_ready=1:
//      store 0x0000_0010 <- 0xDEAD_BEEF, then load 0x10.
//      -> rsp_valid 3 cycles after each accept; load rsp_rdata=0xDEAD_BEEF.
//   2. Back-pressure: load 0x10 with rsp_ready=0 for 5 cycles.
//      -> rsp_valid=1 and rsp_rdata=0xDEAD_BEEF held stable; req_ready=0 throughout;
//         returns to IDLE one edge after rsp_ready=1.
//   3. Wrap: DEPTH_WORDS=1024, store 0x0000_1004 <- 0x1234_5678, then load 0x4.
//      -> rsp_rdata=0x1234_5678.
//   4. Zero wait: WAIT_CYCLES=0, back-to-back loads.
//      -> rsp_valid the cycle after accept; one request per 2 cycles.
//   5. Reset mid-op: store 0x20 <- 0xAAAA_5555, rst_n=0 one cycle after accept, then load 0x20.
//      -> no rsp_valid before reset; load returns prior contents, not 0xAAAA_5555.
//   6. Misaligned store 0x0000_0022 <- 0xFFFF_FFFF:
//      with MISALIGN_ERR_EN -> rsp_err=1 and mem[8] unchanged;
//      without -> rsp_err=0 and mem[8]=0xFFFF_FFFF.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target: valid/ready request, WAIT_CYCLES wait states, valid/ready response.
// Optional macro MISALIGN_ERR_EN reports word-misaligned accesses on rsp_err and suppresses them.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            write_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            mis_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_mis;
  logic            accept;
  logic            enter_resp;
  logic            ent_write;
  logic            ent_mis;
  logic [AW-1:0]   ent_idx;
  logic [31:0]     ent_wdata;
  logic [31:0]     rsp_rdata_d;
  logic            unused_addr;

  // Upper address bits wrap by design; low bits only matter with the error check.
  assign unused_addr = ^req_addr;

`ifdef MISALIGN_ERR_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;

  // With zero wait states the RESP-entry edge is the accept edge, so use the live request.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      enter_resp = accept;
      ent_write  = req_write;
      ent_idx    = req_addr[AW+1:2];
      ent_wdata  = req_wdata;
      ent_mis    = req_mis;
    end else begin
      enter_resp = (state_q == S_WAIT) && (cnt_q == 4'd0);
      ent_write  = write_q;
      ent_idx    = idx_q;
      ent_wdata  = wdata_q;
      ent_mis    = mis_q;
    end
    rsp_rdata_d = (ent_write || ent_mis) ? 32'd0 : mem[ent_idx];
  end

  // Store commits on the RESP-entry edge, ahead of its response.
  always_ff @(posedge clk) begin
    if (enter_resp && ent_write && !ent_mis) begin
      mem[ent_idx] <= ent_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      mis_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            write_q     <= req_write;
            idx_q       <= req_addr[AW+1:2];
            wdata_q     <= req_wdata;
            mis_q       <= req_mis;
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
            cnt_q       <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        state_q     <= S_RESP;
        rsp_valid_q <= 1'b1;
        req_ready_q <= 1'b0;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= ent_mis;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef MISALIGN_ERR_EN
  assign rsp_err = rsp_err_q;
`else
  logic unused_err;
  assign unused_err = rsp_err_q;
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
// Honours MISALIGN_ERR_EN for the misaligned-store step.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic w, input logic [31:0] ad,
                       input logic [31:0] d);
    if (s == 0) begin
      a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wdata = d;
    end else begin
      b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wdata = d;
    end
  endtask

  // Issue one request and return the number of sampled cycles until rsp_valid.
  task automatic req(input int s, input logic w, input logic [31:0] ad, input logic [31:0] d,
                     output int l);
    int t;
    t = 0;
    while (!((s != 0) ? b_req_ready : a_req_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    drive(s, 1'b1, w, ad, d);
    @(negedge clk);
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
    l = 1;
    while (!((s != 0) ? b_rsp_valid : a_rsp_valid) && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic rsp(input int s);
    if (s == 0) a_rsp_ready = 1'b1; else b_rsp_ready = 1'b1;
    @(negedge clk);
    if (s == 0) a_rsp_ready = 1'b0; else b_rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", a_req_ready, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_rsp_err",   a_rsp_err,   0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", a_req_ready, 1);

    // Store then load, two wait states
    req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat);
    chk("st_latency", lat, 3);
    chk("st_rdata",   a_rsp_rdata, 0);
    chk("st_err",     a_rsp_err,   0);
    rsp(0);
    chk("st_done_valid", a_rsp_valid, 0);
    req(0, 1'b0, 32'h0000_0010, 32'd0, lat);
    chk("ld_latency", lat, 3);
    chk("ld_rdata",   a_rsp_rdata, 32'hDEAD_BEEF);
    rsp(0);

    // Back-pressure for five cycles
    req(0, 1'b0, 32'h0000_0010, 32'd0, lat);
    chk("bp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", a_rsp_valid, 1);
      chk("bp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_ready", a_req_ready, 0);
      @(negedge clk);
    end
    rsp(0);
    chk("bp_release_valid", a_rsp_valid, 0);
    chk("bp_release_ready", a_req_ready, 1);

    // Address wrap modulo 4 KiB
    req(0, 1'b1, 32'h0000_1004, 32'h1234_5678, lat);
    rsp(0);
    req(0, 1'b0, 32'h0000_0004, 32'd0, lat);
    chk("wrap_rdata", a_rsp_rdata, 32'h1234_5678);
    rsp(0);

    // Zero wait states
    req(1, 1'b1, 32'h0000_0040, 32'h1111_1111, lat);
    chk("w0_st_latency", lat, 1);
    rsp(1);
    req(1, 1'b1, 32'h0000_0044, 32'h2222_2222, lat);
    rsp(1);
    b_rsp_ready = 1'b1;
    drive(1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
    @(negedge clk);
    chk("b2b_valid0", b_rsp_valid, 1);
    chk("b2b_rdata0", b_rsp_rdata, 32'h1111_1111);
    chk("b2b_ready0", b_req_ready, 0);
    drive(1, 1'b1, 1'b0, 32'h0000_0044, 32'd0);
    @(negedge clk);
    chk("b2b_gap_valid", b_rsp_valid, 0);
    chk("b2b_gap_ready", b_req_ready, 1);
    @(negedge clk);
    chk("b2b_valid1", b_rsp_valid, 1);
    chk("b2b_rdata1", b_rsp_rdata, 32'h2222_2222);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("b2b_end_valid", b_rsp_valid, 0);
    b_rsp_ready = 1'b0;

    // Reset one cycle after accepting a store
    req(0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, lat);
    rsp(0);
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'hAAAA_5555);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("midrst_no_valid", a_rsp_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", a_req_ready, 0);
    chk("midrst_rsp_valid", a_rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_valid", a_rsp_valid, 0);
    chk("postrst_ready", a_req_ready, 1);
    req(0, 1'b0, 32'h0000_0020, 32'd0, lat);
    chk("postrst_rdata", a_rsp_rdata, 32'h0BAD_F00D);
    rsp(0);

    // Misaligned store to word 8
    req(0, 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, lat);
    chk("mis_latency", lat, 3);
    chk("mis_rdata",   a_rsp_rdata, 0);
`ifdef MISALIGN_ERR_EN
    chk("mis_err", a_rsp_err, 1);
`else
    chk("mis_err", a_rsp_err, 0);
`endif
    rsp(0);
    req(0, 1'b0, 32'h0000_0020, 32'd0, lat);
`ifdef MISALIGN_ERR_EN
    chk("mis_word8", a_rsp_rdata, 32'h0BAD_F00D);
`else
    chk("mis_word8", a_rsp_rdata, 32'hFFFF_FFFF);
`endif
    chk("mis_load_err", a_rsp_err, 0);
    rsp(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
